pio_bank: RTL and testbench

//  Parametrised Avalon-MM PIO bank: next-generation replacement for the fixed 32-bit control PIO and 2-bit key PIO in the SoC.

---
 rtl/pio_bank.sv | 182 ++++++++++++++++++
 tb/tb_pio_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_bank.sv
// Avalon-MM PIO bank: debounced edge-capturing inputs with irq, and set/clear outputs.
// Define PIO_BANK_DEBOUNCE_EN for debounce counters; otherwise DIN follows the synchroniser.

module pio_bank_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic din_nxt,
  output logic din
);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("pio_bank_lane: SYNC_STAGES must be >=2 and DEBOUNCE_CYCLES >=1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   din_q, din_d;
  logic                   sync;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign din     = din_q;
  assign din_nxt = din_d;

`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with DIN.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    din_d  = din_q;
    cnt_d  = '0;
    if (sync != din_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) din_d = sync;
      else                                 cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      din_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      din_q  <= din_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    din_d  = sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      din_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      din_q  <= din_d;
    end
  end
`endif
endmodule

module pio_bank #(
  parameter int                   IN_WIDTH        = 2,
  parameter int                   OUT_WIDTH       = 32,
  parameter int                   SYNC_STAGES     = 2,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  in_export,
  output logic [OUT_WIDTH-1:0] out_export
);
  if (IN_WIDTH < 1 || IN_WIDTH > 32 || OUT_WIDTH < 1 || OUT_WIDTH > 32) begin : g_bad_width
    $error("pio_bank: IN_WIDTH and OUT_WIDTH must be 1..32");
  end

  localparam logic [2:0] A_DIN = 3'd0, A_DOUT = 3'd1, A_MASK = 3'd2, A_EDGE = 3'd3,
                         A_SET = 3'd4, A_CLR  = 3'd5, A_RISE = 3'd6, A_FALL = 3'd7;

  logic [IN_WIDTH-1:0]  din, din_nxt;
  logic [IN_WIDTH-1:0]  mask_q, mask_d, edge_q, edge_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [IN_WIDTH-1:0]  w1c, cap;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q, irq_d;
  logic [IN_WIDTH-1:0]  wd_in;
  logic [OUT_WIDTH-1:0] wd_out;
  logic                 unused_wdata;

  assign wd_in        = avs_writedata[IN_WIDTH-1:0];
  assign wd_out       = avs_writedata[OUT_WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_lane
    pio_bank_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk    (clk_clk),
      .rst    (reset_reset),
      .raw    (in_export[i]),
      .din_nxt(din_nxt[i]),
      .din    (din[i])
    );
  end

  always_comb begin
    dout_d    = dout_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (avs_write) begin
      case (avs_address)
        A_DOUT:  dout_d    = wd_out;
        A_MASK:  mask_d    = wd_in;
        A_EDGE:  w1c       = wd_in;
        A_SET:   dout_d    = dout_q | wd_out;
        A_CLR:   dout_d    = dout_q & ~wd_out;
        A_RISE:  rise_en_d = wd_in;
        A_FALL:  fall_en_d = wd_in;
        default: ;
      endcase
    end
    // Capture is taken from the lane's next DIN so the flag lands with the DIN update; set beats clear.
    cap    = (din_nxt & ~din & rise_en_q) | (~din_nxt & din & fall_en_q);
    edge_d = (edge_q & ~w1c) | cap;
    irq_d  = |(edge_q & mask_q);

    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        A_DIN:   rdata_d = 32'(din);
        A_DOUT:  rdata_d = 32'(dout_q);
        A_MASK:  rdata_d = 32'(mask_q);
        A_EDGE:  rdata_d = 32'(edge_q);
        A_RISE:  rdata_d = 32'(rise_en_q);
        A_FALL:  rdata_d = 32'(fall_en_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      dout_q    <= OUT_RESET;
      mask_q    <= '0;
      edge_q    <= '0;
      rise_en_q <= '1;
      fall_en_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      dout_q    <= dout_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign out_export   = dout_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;
endmodule

// File: tb/tb_pio_bank.sv
// Bench for pio_bank: directed scenarios plus random traffic against a windowed reference model.
module tb_pio_bank;
  localparam int IW = 2, OW = 8, SS = 2, DC = 4;
`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int DEFF = DC;
`else
  localparam int DEFF = 1;
`endif
  localparam int LAT = SS + DEFF;

  logic          clk = 1'b0, rst = 1'b1;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0, avs_readdata;
  logic          irq;
  logic [IW-1:0] in_export = '0;
  logic [OW-1:0] out_export;

  int n_tests = 0, n_fail = 0;

  pio_bank #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
             .OUT_RESET(8'hA5)) dut (
    .clk_clk(clk), .reset_reset(rst), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .in_export(in_export), .out_export(out_export));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: DIN flips once the last DEFF synchronised samples all disagree with it.
  logic [IW-1:0] din_m, edge_m, mask_m, rise_m, fall_m;
  logic [OW-1:0] dout_m;
  logic          irq_m;
  logic [31:0]   rd_m;
  logic [IW-1:0] rawq[$], syncq[$];

  function automatic logic [31:0] reg_rd(input logic [2:0] a);
    case (a)
      3'd0: return 32'(din_m);
      3'd1: return 32'(dout_m);
      3'd2: return 32'(mask_m);
      3'd3: return 32'(edge_m);
      3'd6: return 32'(rise_m);
      3'd7: return 32'(fall_m);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      din_m = '0; edge_m = '0; mask_m = '0; rise_m = '1; fall_m = '0;
      dout_m = 8'hA5; irq_m = 1'b0; rd_m = '0;
      rawq.delete(); syncq.delete();
    end else begin : model_step
      logic [IW-1:0] sv, din_n, setb, clrb, wd;
      logic          irq_n, ok;
      wd = avs_writedata[IW-1:0];
      if (avs_read) rd_m = reg_rd(avs_address);
      irq_n = |(edge_m & mask_m);
      rawq.push_back(in_export);
      if (rawq.size() > 64) void'(rawq.pop_front());
      sv = (rawq.size() > SS) ? rawq[rawq.size()-1-SS] : '0;
      syncq.push_back(sv);
      if (syncq.size() > 64) void'(syncq.pop_front());
      din_n = din_m;
      for (int i = 0; i < IW; i++) begin
        ok = (syncq.size() >= DEFF);
        for (int j = 0; j < DEFF && ok; j++)
          if (syncq[syncq.size()-1-j][i] == din_m[i]) ok = 1'b0;
        if (ok) din_n[i] = ~din_m[i];
      end
      setb = (din_n & ~din_m & rise_m) | (~din_n & din_m & fall_m);
      clrb = (avs_write && avs_address == 3'd3) ? wd : '0;
      edge_m = (edge_m & ~clrb) | setb;
      if (avs_write) begin
        case (avs_address)
          3'd1: dout_m = avs_writedata[OW-1:0];
          3'd2: mask_m = wd;
          3'd4: dout_m = dout_m | avs_writedata[OW-1:0];
          3'd5: dout_m = dout_m & ~avs_writedata[OW-1:0];
          3'd6: rise_m = wd;
          3'd7: fall_m = wd;
          default: ;
        endcase
      end
      din_m = din_n;
      irq_m = irq_n;
    end
  end

  always @(negedge clk) begin
    chk("m_out", 32'(out_export), 32'(dout_m));
    chk("m_irq", 32'(irq), 32'(irq_m));
    chk("m_rdata", avs_readdata, rd_m);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk); avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); avs_read = 1'b1; avs_address = a;
    @(negedge clk); avs_read = 1'b0; d = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    idle(2);
    chk("rst_out", 32'(out_export), 32'hA5);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", avs_readdata, 32'h0);
    rst = 1'b0;
    rd(3'd6, d); chk("rise_en_rst", d, 32'h3);
    rd(3'd0, d); chk("din_rst", d, 32'h0);

    wr(3'd1, 32'h0F); chk("dout_wr", 32'(out_export), 32'h0F);
    wr(3'd4, 32'hF0); chk("dout_set", 32'(out_export), 32'hFF);
    wr(3'd5, 32'h03); chk("dout_clr", 32'(out_export), 32'hFC);
    rd(3'd1, d);      chk("dout_rd", d, 32'hFC);

    // Step on in[0]; DIN seen by a continuous read one clock after it updates.
    @(negedge clk); in_export = 2'b01; avs_read = 1'b1; avs_address = 3'd0;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(posedge clk); #1;
      chk("din_lat", avs_readdata, (n == LAT + 1) ? 32'h1 : 32'h0);
    end
    @(negedge clk); avs_read = 1'b0;
    rd(3'd3, d); chk("edge_rise", d, 32'h1);
    wr(3'd2, 32'h1); chk("irq_pre", 32'(irq), 32'h0);
    @(negedge clk);  chk("irq_on", 32'(irq), 32'h1);
    wr(3'd3, 32'h1); chk("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);  chk("irq_off", 32'(irq), 32'h0);

    // Short pulse on in[1].
    @(negedge clk); in_export = 2'b11;
    idle(3); in_export = 2'b01;
    idle(10);
    rd(3'd0, d); chk("glitch_din", d, 32'h1);
    rd(3'd3, d);
`ifdef PIO_BANK_DEBOUNCE_EN
    chk("glitch_edge", d, 32'h0);
`else
    chk("glitch_edge", d, 32'h2);
`endif
    chk("glitch_irq", 32'(irq), 32'h0);
    wr(3'd3, 32'h3);

    // Fall-only capture, then a fall landing on the same clock as its W1C.
    wr(3'd7, 32'h2); wr(3'd6, 32'h0);
    @(negedge clk); in_export = 2'b11; idle(LAT + 4);
    rd(3'd3, d); chk("no_rise_cap", d, 32'h0);
    @(negedge clk); in_export = 2'b01; idle(LAT + 4);
    rd(3'd3, d); chk("fall_cap", d, 32'h2);
    @(negedge clk); in_export = 2'b11; idle(LAT + 4);
    rd(3'd3, d); chk("fall_keep", d, 32'h2);
    @(negedge clk); in_export = 2'b01;
    idle(LAT - 1);
    avs_write = 1'b1; avs_address = 3'd3; avs_writedata = 32'h2;
    @(negedge clk); avs_write = 1'b0;
    rd(3'd3, d); chk("set_beats_clr", d, 32'h2);
    wr(3'd3, 32'h2);
    rd(3'd3, d); chk("w1c", d, 32'h0);

    // Reset mid-debounce with a read in flight.
    rd(3'd1, d); chk("pre_rst_rd", d, 32'hFC);
    @(negedge clk); in_export = 2'b00;
    idle(3);
    avs_read = 1'b1; avs_address = 3'd1;
    #1 rst = 1'b1;
    #1;
    chk("arst_out", 32'(out_export), 32'hA5);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rdata", avs_readdata, 32'h0);
    @(negedge clk); avs_read = 1'b0; rst = 1'b0;
    rd(3'd0, d); chk("post_rst_din", d, 32'h0);
    rd(3'd6, d); chk("post_rst_rise", d, 32'h3);
    @(negedge clk); in_export = 2'b10;
    idle(3); in_export = 2'b00;
    idle(8);
    rd(3'd3, d);
`ifdef PIO_BANK_DEBOUNCE_EN
    chk("post_rst_glitch", d, 32'h0);
`else
    chk("post_rst_glitch", d, 32'h2);
`endif

    // Random traffic; the model checker compares every cycle.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int b = 0; b < IW; b++)
        if ($urandom_range(0, 9) == 0) in_export[b] = ~in_export[b];
      avs_address   = 3'($urandom_range(0, 7));
      avs_writedata = $urandom();
      avs_read      = ($urandom_range(0, 2) == 0);
      avs_write     = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); avs_read = 1'b0; avs_write = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
